// File: rtl/mem_bus_arb_pkg.sv
// ============================================================================
// Module      : mem_bus_arb_pkg
// Description : Shared types and constants for the memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_wait_counter.sv
// ============================================================================
// Module      : wait_counter
// Description : Loadable 4-bit down-counter with zero flag; times ACCESS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_counter
    import mem_bus_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Arbitrates the shared memory bus between CPU and loader port.
//               MEM_BUS_ARB_STARVE_EN enables loader anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int AW     = 13,
    parameter int DW     = 8,
    parameter int WAIT   = 2,
    parameter int STARVE = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          c_ack,
    output logic          l_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic          w_grant_c;
    logic          w_grant_l;
    logic          w_load;
    logic          w_dec;
    logic          w_capture;
    logic          w_cnt_zero;
    logic          w_starved;

`ifdef MEM_BUS_ARB_STARVE_EN
    logic [3:0] r_streak;

    assign w_starved = (r_streak == 4'(STARVE));

    // Streak counts CPU wins only while the loader is actually waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (!l_req || w_grant_l) begin
                r_streak <= '0;
            end else if (w_grant_c && !w_starved) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end
`else
    logic [3:0] w_starve_unused;

    assign w_starve_unused = 4'(STARVE);
    assign w_starved       = 1'b0;
`endif

    always_comb begin
        w_grant_c    = 1'b0;
        w_grant_l    = 1'b0;
        w_state_next = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (c_req && !(l_req && w_starved)) begin
                    w_grant_c = 1'b1;
                end else if (l_req) begin
                    w_grant_l = 1'b1;
                end
                if (w_grant_c || w_grant_l) begin
                    w_state_next = ACCESS;
                    w_load       = 1'b1;
                end
            end
            ACCESS: begin
                if (w_cnt_zero) begin
                    w_state_next = ACK;
                    w_capture    = !r_we;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_c || w_grant_l) begin
                r_owner     <= w_grant_l ? OWN_LDR : OWN_CPU;
                r_we        <= w_grant_l ? l_we    : c_we;
                r_mem_addr  <= w_grant_l ? l_addr  : c_addr;
                r_mem_wdata <= w_grant_l ? l_wdata : c_wdata;
            end
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    wait_counter u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (4'(WAIT - 1)),
        .dec      (w_dec),
        .zero     (w_cnt_zero)
    );

    // Strobes and acks decode straight from state so an async reset drops them at once.
    assign mem_rd    = (r_state == ACCESS) && !r_we;
    assign mem_wr    = (r_state == ACCESS) &&  r_we;
    assign c_ack     = (r_state == ACK) && (r_owner == OWN_CPU);
    assign l_ack     = (r_state == ACK) && (r_owner == OWN_LDR);
    assign busy      = (r_state == ACCESS) || (r_state == ACK);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter (WAIT=2 and WAIT=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

    localparam int AW     = 13;
    localparam int DW     = 8;
    localparam int WAIT   = 2;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [AW-1:0] c_addr = '0, l_addr = '0;
    logic [DW-1:0] c_wdata = '0, l_wdata = '0;
    logic          c_ack, l_ack, mem_rd, mem_wr, busy;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          b_c_req = 1'b0, b_c_we = 1'b0, b_l_req = 1'b0, b_l_we = 1'b0;
    logic [AW-1:0] b_c_addr = '0, b_l_addr = '0;
    logic [DW-1:0] b_c_wdata = '0, b_l_wdata = '0;
    logic          b_c_ack, b_l_ack, b_mem_rd, b_mem_wr, b_busy;
    logic [DW-1:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            rd_cnt  = 0;
    int            m_streak = 0;
    logic [DW-1:0] m_rdata = '0;

    always #5 clk = ~clk;

    // Memory device: data depends on address and is only valid in the last strobe cycle.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'hB5;
    endfunction

    always @(posedge clk) rd_cnt <= mem_rd ? rd_cnt + 1 : 0;
    assign mem_rdata   = (mem_rd && rd_cnt == WAIT - 1) ? mem_val(mem_addr) : 8'hEE;
    assign b_mem_rdata = b_mem_rd ? mem_val(b_mem_addr) : 8'hEE;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT), .STARVE(STARVE)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .c_ack(c_ack), .l_ack(l_ack), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT(1), .STARVE(STARVE)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .l_req(b_l_req), .l_we(b_l_we), .l_addr(b_l_addr), .l_wdata(b_l_wdata),
        .c_ack(b_c_ack), .l_ack(b_l_ack), .rdata(b_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, c_ack, l_ack, mem_rd, mem_wr, mem_addr, mem_wdata, rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got busy=%b acks=%b%b rd/wr=%b%b addr=%h wd=%h rdata=%h, required all 0",
                     busy, c_ack, l_ack, mem_rd, mem_wr, mem_addr, mem_wdata, rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, c_ack, l_ack, mem_rd, mem_wr, mem_addr, mem_wdata, rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b rd/wr=%b%b addr=%h rdata=%h, required all 0",
                     busy, mem_rd, mem_wr, mem_addr, rdata);
        end
        n_tests++;
        if ({b_busy, b_c_ack, b_l_ack, b_mem_rd, b_mem_wr, b_mem_addr, b_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b rd/wr=%b%b addr=%h rdata=%h, required all 0",
                     b_busy, b_mem_rd, b_mem_wr, b_mem_addr, b_rdata);
        end
    endtask

    task automatic test_cpu_read();
        logic [4:0] exp_v;
        @(negedge clk);
        c_we = 1'b0; c_addr = 13'h0010; c_req = 1'b1;
        for (int k = 1; k <= WAIT + 2; k++) begin
            @(negedge clk);
            exp_v = {k <= WAIT, 1'b0, k == WAIT + 1, 1'b0, k <= WAIT + 1};
            n_tests++;
            if ({mem_rd, mem_wr, c_ack, l_ack, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL cpu_read_ctl k=%0d: got rd,wr,cack,lack,busy=%b required %b",
                         k, {mem_rd, mem_wr, c_ack, l_ack, busy}, exp_v);
            end
            if (k == WAIT + 1) begin
                m_rdata = 8'hA5;
                n_tests++;
                if (rdata !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL cpu_read_data: got rdata=%h required a5", rdata);
                end
                c_req = 1'b0;
            end
        end
    endtask

    task automatic test_ldr_write();
        logic [4:0] exp_v;
        @(negedge clk);
        l_we = 1'b1; l_addr = 13'h1FFF; l_wdata = 8'h3C; l_req = 1'b1;
        for (int k = 1; k <= WAIT + 1; k++) begin
            @(negedge clk);
            exp_v = {1'b0, k <= WAIT, 1'b0, k == WAIT + 1, 1'b1};
            n_tests++;
            if ({mem_rd, mem_wr, c_ack, l_ack, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL ldr_write_ctl k=%0d: got %b required %b",
                         k, {mem_rd, mem_wr, c_ack, l_ack, busy}, exp_v);
            end
            if (k <= WAIT) begin
                n_tests++;
                if (mem_addr !== 13'h1FFF || mem_wdata !== 8'h3C) begin
                    n_fail++;
                    $display("FAIL ldr_write_bus k=%0d: got addr=%h wdata=%h required 1fff/3c",
                             k, mem_addr, mem_wdata);
                end
            end else begin
                n_tests++;
                if (rdata !== m_rdata) begin
                    n_fail++;
                    $display("FAIL ldr_write_rdata: got rdata=%h required %h", rdata, m_rdata);
                end
                l_req = 1'b0;
            end
        end
        m_streak = 0;
    endtask

    task automatic test_random();
        int            gap;
        int            sel;
        logic          win_l;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [4:0]    exp_v;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            if (gap > 0) m_streak = 0;
            sel     = $urandom_range(0, 3);
            c_we    = 1'($urandom);  l_we    = 1'($urandom);
            c_addr  = 13'($urandom); l_addr  = 13'($urandom);
            c_wdata = 8'($urandom);  l_wdata = 8'($urandom);
            c_req   = (sel != 1);
            l_req   = (sel != 0);
            if (c_req && l_req) begin
`ifdef MEM_BUS_ARB_STARVE_EN
                if (m_streak == STARVE) begin win_l = 1'b1; m_streak = 0; end
                else begin win_l = 1'b0; m_streak = m_streak + 1; end
`else
                win_l = 1'b0;
`endif
            end else begin
                win_l    = l_req;
                m_streak = 0;
            end
            we   = win_l ? l_we    : c_we;
            addr = win_l ? l_addr  : c_addr;
            wd   = win_l ? l_wdata : c_wdata;
            for (int k = 1; k <= WAIT + 1; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    c_addr  = 13'($urandom); l_addr  = 13'($urandom);
                    c_wdata = 8'($urandom);  l_wdata = 8'($urandom);
                end
                exp_v = {(k <= WAIT) && !we, (k <= WAIT) && we,
                         (k == WAIT + 1) && !win_l, (k == WAIT + 1) && win_l, 1'b1};
                n_tests++;
                if ({mem_rd, mem_wr, c_ack, l_ack, busy} !== exp_v) begin
                    n_fail++;
                    $display("FAIL rand_ctl t=%0d k=%0d: got %b required %b",
                             t, k, {mem_rd, mem_wr, c_ack, l_ack, busy}, exp_v);
                end
                if (k <= WAIT) begin
                    n_tests++;
                    if (mem_addr !== addr || mem_wdata !== wd) begin
                        n_fail++;
                        $display("FAIL rand_bus t=%0d k=%0d: got addr=%h wd=%h required %h/%h",
                                 t, k, mem_addr, mem_wdata, addr, wd);
                    end
                end else begin
                    if (!we) m_rdata = mem_val(addr);
                    n_tests++;
                    if (rdata !== m_rdata) begin
                        n_fail++;
                        $display("FAIL rand_rdata t=%0d: got %h required %h", t, rdata, m_rdata);
                    end
                    c_req = 1'b0;
                    l_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [1:0]    exp_v;
        int            j;
        for (int i = 0; i < 3; i++) addrs[i] = 13'($urandom);
        j = 0;
        @(negedge clk);
        b_c_we = 1'b0; b_c_addr = addrs[0]; b_c_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_v = {k % 3 == 1, k % 3 == 2};
            n_tests++;
            if ({b_mem_rd, b_c_ack} !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_ctl k=%0d: got rd,ack=%b required %b", k, {b_mem_rd, b_c_ack}, exp_v);
            end
            if (k % 3 == 1) begin
                n_tests++;
                if (b_mem_addr !== addrs[j]) begin
                    n_fail++;
                    $display("FAIL b2b_addr k=%0d: got %h required %h", k, b_mem_addr, addrs[j]);
                end
            end else if (k % 3 == 2) begin
                n_tests++;
                if (b_rdata !== mem_val(addrs[j])) begin
                    n_fail++;
                    $display("FAIL b2b_rdata k=%0d: got %h required %h", k, b_rdata, mem_val(addrs[j]));
                end
                j++;
                if (j < 3) b_c_addr = addrs[j];
                else       b_c_req  = 1'b0;
            end
        end
    endtask

    task automatic test_starvation();
        logic exp_l [10];
        int   streak;
        int   acks;
        int   cyc;
        logic got;
        @(negedge clk);
        @(negedge clk);
        c_we = 1'b0; l_we = 1'b0; c_req = 1'b1; l_req = 1'b1;
        streak = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_BUS_ARB_STARVE_EN
            if (streak == STARVE) begin exp_l[i] = 1'b1; streak = 0; end
            else begin exp_l[i] = 1'b0; streak = streak + 1; end
`else
            exp_l[i] = 1'b0;
`endif
        end
        acks = 0;
        cyc  = 0;
        while (acks < 10 && cyc < 10 * (WAIT + 2) + 8) begin
            @(negedge clk);
            cyc++;
            if (c_ack || l_ack) begin
                n_tests++;
                if (l_ack !== exp_l[acks] || c_ack !== !exp_l[acks] ||
                    cyc != (WAIT + 1) + acks * (WAIT + 2)) begin
                    n_fail++;
                    $display("FAIL starve_order ack=%0d: got cack=%b lack=%b at cycle %0d required lack=%b at cycle %0d",
                             acks, c_ack, l_ack, cyc, exp_l[acks], (WAIT + 1) + acks * (WAIT + 2));
                end
                acks++;
                if (acks == 10) c_req = 1'b0;
            end
        end
        if (acks < 10) begin
            n_tests++;
            n_fail++;
            $display("FAIL starve_timeout: got %0d acks required 10", acks);
            c_req = 1'b0;
        end
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 2 * (WAIT + 2) + 4) begin
            @(negedge clk);
            cyc++;
            if (c_ack || l_ack) begin
                got = 1'b1;
                n_tests++;
                if (!(l_ack === 1'b1 && c_ack === 1'b0)) begin
                    n_fail++;
                    $display("FAIL ldr_after_cpu_drop: got cack=%b lack=%b required lack only", c_ack, l_ack);
                end
                l_req = 1'b0;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL ldr_after_cpu_drop_timeout: got no ack required l_ack");
            l_req = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        logic [4:0] exp_v;
        @(negedge clk);
        c_we = 1'b0; c_addr = 13'h0123; c_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: got mem_rd=%b required 1", mem_rd);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, c_ack, l_ack, mem_rd, mem_wr, mem_addr, mem_wdata, rdata} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b acks=%b%b rd/wr=%b%b addr=%h rdata=%h required all 0",
                     busy, c_ack, l_ack, mem_rd, mem_wr, mem_addr, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= WAIT + 1; k++) begin
            @(negedge clk);
            exp_v = {k <= WAIT, 1'b0, k == WAIT + 1, 1'b0, 1'b1};
            n_tests++;
            if ({mem_rd, mem_wr, c_ack, l_ack, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL abort_regrant k=%0d: got %b required %b",
                         k, {mem_rd, mem_wr, c_ack, l_ack, busy}, exp_v);
            end
            if (k == WAIT + 1) begin
                n_tests++;
                if (rdata !== mem_val(13'h0123)) begin
                    n_fail++;
                    $display("FAIL abort_rdata: got %h required %h", rdata, mem_val(13'h0123));
                end
                c_req = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_random();
        test_back_to_back();
        test_starvation();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
